// File: rtl/permutation_sequencer.sv
// Round sequencer for a p^a / p^b permutation datapath: IDLE -> FIRST -> RUN -> DONE.
// Define PERM_SEQ_ABORT_EN to add abort_i, which cancels a running permutation.
module permutation_sequencer #(
   parameter int NB_ROUNDS_A = 12,
   parameter int NB_ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       rounds_sel_i,
   input  logic       xor_en_i,
   input  logic       xor_src_i,
`ifdef PERM_SEQ_ABORT_EN
   input  logic       abort_i,
`endif
   output logic       ready_o,
   output logic       done_o,
   output logic       selectionp_o,
   output logic       enable_o,
   output logic       bypass_o,
   output logic       mode_int_ext_o,
   output logic [3:0] round_o
);

   typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;

   // Every run ends on constant 11, so only the starting index 12-N needs storing.
   localparam logic [3:0] LastRound   = 4'd11;
   localparam logic [3:0] FirstRoundA = 4'(12 - NB_ROUNDS_A);
   localparam logic [3:0] FirstRoundB = 4'(12 - NB_ROUNDS_B);

   state_t     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       xorEn_q, xorEn_d;
   logic       xorSrc_q, xorSrc_d;
   logic       abortReq;

`ifdef PERM_SEQ_ABORT_EN
   assign abortReq = abort_i;
`else
   assign abortReq = 1'b0;
`endif

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         round_q  <= 4'd0;
         xorEn_q  <= 1'b0;
         xorSrc_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         xorEn_q  <= xorEn_d;
         xorSrc_q <= xorSrc_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      xorEn_d        = xorEn_q;
      xorSrc_d       = xorSrc_q;
      ready_o        = 1'b0;
      done_o         = 1'b0;
      enable_o       = 1'b0;
      selectionp_o   = 1'b0;
      bypass_o       = 1'b1;
      mode_int_ext_o = 1'b0;
      round_o        = 4'd0;

      case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               xorEn_d  = xor_en_i;
               xorSrc_d = xor_src_i;
               round_d  = rounds_sel_i ? FirstRoundA : FirstRoundB;
               state_d  = FIRST;
            end
         end
         FIRST, RUN: begin
            enable_o       = 1'b1;
            selectionp_o   = (state_q == RUN);
            bypass_o       = (state_q == RUN) ? 1'b1 : !xorEn_q;
            mode_int_ext_o = xorSrc_q;
            round_o        = round_q;
            if (abortReq) begin
               state_d = IDLE;
            end else if (round_q == LastRound) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            done_o         = 1'b1;
            mode_int_ext_o = xorSrc_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_permutation_sequencer.sv
// Randomized scoreboard bench for permutation_sequencer, plus a second instance with NB_ROUNDS_B=1.
module tb_permutation_sequencer;

   localparam int NA = 12;
   localparam int NB = 6;

   typedef struct {
      bit         isDone;
      logic [3:0] round;
      bit         bypass;
      bit         sel;
      bit         mode;
   } beat_t;

   logic clock_i = 1'b0;
   logic resetIn = 1'b1;
   logic startIn = 1'b0, selIn = 1'b0, xenIn = 1'b0, xsrcIn = 1'b0;
   logic readyO, doneO, selO, enableO, bypassO, modeO;
   logic [3:0] roundO;

   logic start1 = 1'b0, xen1 = 1'b0, xsrc1 = 1'b0;
   logic ready1, done1, sel1, enable1, bypass1, mode1;
   logic [3:0] round1;

`ifdef PERM_SEQ_ABORT_EN
   logic abortIn = 1'b0;
`endif

   beat_t sbQ[$];
   int    busyLeft = 0;
   int    checks = 0;
   int    passes = 0;
   int    doneFirst = -1;
   int    doneSecond = -1;

   always #5 clock_i = ~clock_i;

   permutation_sequencer #(.NB_ROUNDS_A(NA), .NB_ROUNDS_B(NB)) dut (
      .clock_i(clock_i), .reset_i(resetIn), .start_i(startIn), .rounds_sel_i(selIn),
      .xor_en_i(xenIn), .xor_src_i(xsrcIn),
`ifdef PERM_SEQ_ABORT_EN
      .abort_i(abortIn),
`endif
      .ready_o(readyO), .done_o(doneO), .selectionp_o(selO), .enable_o(enableO),
      .bypass_o(bypassO), .mode_int_ext_o(modeO), .round_o(roundO)
   );

   permutation_sequencer #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(1)) dutOne (
      .clock_i(clock_i), .reset_i(resetIn), .start_i(start1), .rounds_sel_i(1'b0),
      .xor_en_i(xen1), .xor_src_i(xsrc1),
`ifdef PERM_SEQ_ABORT_EN
      .abort_i(1'b0),
`endif
      .ready_o(ready1), .done_o(done1), .selectionp_o(sel1), .enable_o(enable1),
      .bypass_o(bypass1), .mode_int_ext_o(mode1), .round_o(round1)
   );

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: an accepted request yields N enabled beats (indices 12-N..11) then a done beat,
   // and the sequencer is busy for N+1 cycles after the accepting edge.
   task automatic modelEdge();
      int n;
      if (resetIn) begin
         busyLeft = 0;
         sbQ.delete();
      end else if (busyLeft == 0) begin
         if (startIn) begin
            n = selIn ? NA : NB;
            for (int k = 0; k < n; k++)
               sbQ.push_back('{isDone: 1'b0, round: 4'(12 - n + k),
                               bypass: (k == 0) ? !xenIn : 1'b1, sel: (k != 0), mode: xsrcIn});
            sbQ.push_back('{isDone: 1'b1, round: 4'd0, bypass: 1'b1, sel: 1'b0, mode: xsrcIn});
            busyLeft = n + 1;
         end
`ifdef PERM_SEQ_ABORT_EN
      end else if (abortIn && busyLeft >= 2) begin
         busyLeft = 0;
         sbQ.delete();
`endif
      end else begin
         busyLeft--;
      end
   endtask

   task automatic stepCycle();
      @(posedge clock_i);
      modelEdge();
      @(negedge clock_i);
      if (busyLeft == 0)
         checkOutput("idle_outputs", {readyO, doneO, enableO, selO, bypassO, modeO, roundO},
                     {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
      else
         checkOutput("busy_not_ready", 16'(readyO), 16'd0);
   endtask

   task automatic applyStimulus(input logic s, input logic rs, input logic xe, input logic xs);
      startIn = s;
      selIn   = rs;
      xenIn   = xe;
      xsrcIn  = xs;
      stepCycle();
   endtask

   // Monitor: every enabled or done cycle must match the next expected beat.
   always @(negedge clock_i) begin : monitor
      beat_t e;
      if (enableO === 1'b1 || doneO === 1'b1) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_output", {doneO, enableO}, 16'd0);
         end else begin
            e = sbQ.pop_front();
            if (e.isDone)
               checkOutput("done_beat", {readyO, enableO, doneO, modeO},
                           {1'b0, 1'b0, 1'b1, e.mode});
            else
               checkOutput("round_beat", {readyO, doneO, enableO, selO, bypassO, modeO, roundO},
                           {1'b0, 1'b0, 1'b1, e.sel, e.bypass, e.mode, e.round});
         end
      end
   end

   initial begin
      @(negedge clock_i);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      resetIn = 1'b0;

      // Full p^a run, then p^b with a keyed begin-XOR.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < NA + 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < NB + 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

      // start_i held high: the second accept only happens back in IDLE.
      for (int c = 0; c < 20; c++) begin
         applyStimulus((c < 16) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
         if (doneO === 1'b1) begin
            if (doneFirst < 0) doneFirst = c + 1;
            else if (doneSecond < 0) doneSecond = c + 1;
         end
      end
      checkOutput("held_done_first", 16'(doneFirst), 16'(NB + 1));
      checkOutput("held_done_second", 16'(doneSecond), 16'(2 * NB + 3));

      // Asynchronous reset at round index 4 of a 12-round run, then an immediate restart.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #2 resetIn = 1'b1;
      #1 checkOutput("async_reset", {readyO, doneO, enableO, selO, bypassO, modeO, roundO},
                     {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
      sbQ.delete();
      busyLeft = 0;
      @(negedge clock_i);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      resetIn = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("accept_after_reset", 16'(enableO), 16'd1);
      for (int i = 0; i < NB + 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // Single-round configuration goes straight from FIRST to DONE.
      start1 = 1'b1;
      xen1   = 1'b1;
      xsrc1  = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      start1 = 1'b0;
      checkOutput("one_round_first", {ready1, done1, enable1, sel1, bypass1, mode1, round1},
                  {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd11});
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("one_round_done", {ready1, done1, enable1, mode1}, {1'b0, 1'b1, 1'b0, 1'b1});
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("one_round_idle", {ready1, done1, enable1}, {1'b1, 1'b0, 1'b0});

`ifdef PERM_SEQ_ABORT_EN
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      abortIn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      abortIn = 1'b0;
      checkOutput("abort_to_idle", {readyO, enableO, doneO}, {1'b1, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`endif

      // Random traffic, including input changes while busy.
      for (int i = 0; i < 400; i++)
         applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < NA + 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("scoreboard_empty", 16'(sbQ.size()), 16'd0);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
